// File: rtl/spi_wrapper_pkg.sv
// Shared definitions for the SPI-fronted serial memory peripheral:
// FSM state encoding, command codes, frame/data widths and the frame payload.
package spi_wrapper_pkg;

    localparam int unsigned DEF_MEM_DEPTH = 256;
    localparam int unsigned DEF_ADDR_SIZE = 8;
    localparam int unsigned FRAME_LEN     = 10;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned CNT_W         = 4;   // holds 0..FRAME_LEN
    localparam int unsigned TX_CNT_W      = 3;   // holds 0..DATA_W-1

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    // One received frame: command in [9:8], address/data in [7:0]
    typedef struct packed {
        cmd_t              cmd;
        logic [DATA_W-1:0] payload;
    } frame_t;

endpackage

// File: rtl/spi_wrapper_ram.sv
// Single-clock MEM_DEPTH x 8 RAM driven by decoded SPI frames.
// Ports: clk/rst_n, din/rx_valid frame from the slave,
//        dout/tx_valid read byte back to the slave (1-cycle latency).
module spi_ram
    import spi_wrapper_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  frame_t            din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid
);

    logic [DATA_W-1:0]    mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    // Address registers and read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (din.cmd)
                    CMD_WR_ADDR: wr_addr <= ADDR_SIZE'(din.payload);
                    CMD_RD_ADDR: rd_addr <= ADDR_SIZE'(din.payload);
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (rx_valid && din.cmd == CMD_WR_DATA) mem[wr_addr] <= din.payload;
    end

endmodule

// File: rtl/spi_wrapper_slave.sv
// SPI slave (mode 0, MSB first, oversampled on clk).
// Ports: clk/rst_n, mosi/ss_n serial inputs, miso serial output,
//        rx_data/rx_valid received frame to the RAM,
//        tx_data/tx_valid read byte returned by the RAM.
module spi_slave
    import spi_wrapper_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mosi,
    input  logic              ss_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output frame_t            rx_data,
    output logic              rx_valid,
    output logic              miso
);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      rx_cnt, rx_cnt_nxt;
    logic [FRAME_LEN-1:0]  rx_sreg, rx_sreg_nxt;
    logic                  rx_valid_q, rx_valid_nxt;
    logic [DATA_W-1:0]     tx_sreg, tx_sreg_nxt;
    logic [TX_CNT_W-1:0]   tx_left, tx_left_nxt;
    logic                  tx_active, tx_active_nxt;
    logic                  miso_q, miso_nxt;
    logic                  read_addr_received, rar_nxt;
    logic                  receiving;

    assign receiving = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign rx_data   = rx_sreg;
    assign rx_valid  = rx_valid_q;
    assign miso      = miso_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; SS_n high returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (ss_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CHK_CMD;
                CHK_CMD: begin
                    if (!mosi)                   state_nxt = WRITE;
                    else if (read_addr_received) state_nxt = READ_DATA;
                    else                         state_nxt = READ_ADD;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath next values: frame shift-in and read-byte shift-out
    always_comb begin
        rx_cnt_nxt    = rx_cnt;
        rx_sreg_nxt   = rx_sreg;
        rx_valid_nxt  = 1'b0;
        tx_sreg_nxt   = tx_sreg;
        tx_left_nxt   = tx_left;
        tx_active_nxt = tx_active;
        miso_nxt      = miso_q;
        rar_nxt       = read_addr_received;
        if (ss_n) begin
            // partial frames and pending read-out are dropped
            rx_cnt_nxt    = '0;
            tx_left_nxt   = '0;
            tx_active_nxt = 1'b0;
            miso_nxt      = 1'b0;
        end else begin
            if (!receiving) begin
                rx_cnt_nxt = '0;
            end else if (rx_cnt < CNT_W'(FRAME_LEN)) begin
                rx_sreg_nxt = {rx_sreg[FRAME_LEN-2:0], mosi};
                rx_cnt_nxt  = rx_cnt + 1'b1;
                if (rx_cnt == CNT_W'(FRAME_LEN - 1)) begin
                    rx_valid_nxt = 1'b1;
                    if (state == READ_ADD) rar_nxt = 1'b1;
                end
            end

            if (state == READ_DATA && tx_valid) begin
                miso_nxt      = tx_data[DATA_W-1];
                tx_sreg_nxt   = {tx_data[DATA_W-2:0], 1'b0};
                tx_left_nxt   = TX_CNT_W'(DATA_W - 1);
                tx_active_nxt = 1'b1;
            end else if (tx_active) begin
                if (tx_left != '0) begin
                    miso_nxt    = tx_sreg[DATA_W-1];
                    tx_sreg_nxt = tx_sreg << 1;
                    tx_left_nxt = tx_left - 1'b1;
                end else begin
                    // last bit has been on the line for a full cycle
                    miso_nxt      = 1'b0;
                    tx_active_nxt = 1'b0;
                    rar_nxt       = 1'b0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt             <= '0;
            rx_sreg            <= '0;
            rx_valid_q         <= 1'b0;
            tx_sreg            <= '0;
            tx_left            <= '0;
            tx_active          <= 1'b0;
            miso_q             <= 1'b0;
            read_addr_received <= 1'b0;
        end else begin
            rx_cnt             <= rx_cnt_nxt;
            rx_sreg            <= rx_sreg_nxt;
            rx_valid_q         <= rx_valid_nxt;
            tx_sreg            <= tx_sreg_nxt;
            tx_left            <= tx_left_nxt;
            tx_active          <= tx_active_nxt;
            miso_q             <= miso_nxt;
            read_addr_received <= rar_nxt;
        end
    end

endmodule

// File: rtl/spi_wrapper.sv
// Serial memory peripheral: SPI slave in front of a 256 x 8 RAM.
// Ports: MOSI/SS_n serial inputs, MISO serial read data, clk, rst_n (async, active-low).
module spi_wrapper
    import spi_wrapper_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n,
    input  logic clk,
    input  logic rst_n
);

    frame_t            rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    spi_slave dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mosi     (MOSI),
        .ss_n     (SS_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .miso     (MISO)
    );

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (rx_data),
        .rx_valid (rx_valid),
        .dout     (tx_data),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_spi_wrapper.sv
// Directed self-checking bench for spi_wrapper.
module tb_spi_wrapper;
    import spi_wrapper_pkg::*;

    logic mosi;
    logic miso;
    logic ss_n;
    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;
    int rx_pulses;

    spi_wrapper dut (
        .MOSI  (mosi),
        .MISO  (miso),
        .SS_n  (ss_n),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dut.rx_valid === 1'b1) rx_pulses++;

    // Drive one transaction up to (and holding) the last frame bit, SS_n left low
    task automatic send_frame(input logic cmd_bit, input logic [9:0] frame, input int nbits);
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = cmd_bit;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); mosi = frame[9-i];
        end
    endtask

    task automatic end_txn();
        @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        send_frame(1'b0, {2'b00, addr}, 10); @(negedge clk); end_txn();
        send_frame(1'b0, {2'b01, data}, 10); @(negedge clk); end_txn();
    endtask

    task automatic test_reset();
        ss_n = 1'b1; mosi = 1'b0; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #50;
        tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso got=%b exp=0", miso); end
        tests_run++; if (dut.dut1.state !== IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dut.dut1.state, IDLE); end
        tests_run++; if (dut.rx_valid !== 1'b0 || dut.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valids got=%b%b exp=00", dut.rx_valid, dut.tx_valid); end
        tests_run++; if (dut.dut2.wr_addr !== 8'h00 || dut.dut2.rd_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_addrs got=%h/%h exp=00/00", dut.dut2.wr_addr, dut.dut2.rd_addr); end
        tests_run++; if (dut.dut1.read_addr_received !== 1'b0) begin tests_failed++; $display("FAIL reset_rar got=%b exp=0", dut.dut1.read_addr_received); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset_keeps_mem();
        do_write(8'h10, 8'h5A);
        rst_n = 1'b0;
        #50;
        tests_run++; if (dut.dut2.mem[8'h10] !== 8'h5A) begin tests_failed++; $display("FAIL reset_mem got=%h exp=5a", dut.dut2.mem[8'h10]); end
        tests_run++; if (dut.dut2.wr_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_addr got=%h exp=00", dut.dut2.wr_addr); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_write_addr();
        send_frame(1'b0, 10'b00_1111_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.dut1.state !== WRITE) begin tests_failed++; $display("FAIL wa_state got=%0d exp=%0d", dut.dut1.state, WRITE); end
        tests_run++; if (dut.rx_valid !== 1'b1 || dut.rx_data !== 10'h0F0) begin tests_failed++; $display("FAIL wa_rx got=%b/%h exp=1/0f0", dut.rx_valid, dut.rx_data); end
        @(negedge clk);
        tests_run++; if (dut.dut2.wr_addr !== 8'hF0) begin tests_failed++; $display("FAIL wa_addr got=%h exp=f0", dut.dut2.wr_addr); end
        tests_run++; if (dut.rx_valid !== 1'b0) begin tests_failed++; $display("FAIL wa_pulse got=%b exp=0", dut.rx_valid); end
        tests_run++; if (dut.dut2.mem[8'h10] !== 8'h5A) begin tests_failed++; $display("FAIL wa_mem got=%h exp=5a", dut.dut2.mem[8'h10]); end
        end_txn();
    endtask

    task automatic test_write_data();
        send_frame(1'b0, 10'b01_1010_1110, 10);
        @(negedge clk);
        tests_run++; if (dut.rx_valid !== 1'b1) begin tests_failed++; $display("FAIL wd_rx_valid got=%b exp=1", dut.rx_valid); end
        @(negedge clk);
        tests_run++; if (dut.dut2.mem[8'hF0] !== 8'hAE) begin tests_failed++; $display("FAIL wd_mem got=%h exp=ae", dut.dut2.mem[8'hF0]); end
        end_txn();
    endtask

    task automatic test_read_addr();
        send_frame(1'b1, 10'b10_1111_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.dut1.state !== READ_ADD) begin tests_failed++; $display("FAIL ra_state got=%0d exp=%0d", dut.dut1.state, READ_ADD); end
        tests_run++; if (dut.dut1.read_addr_received !== 1'b1) begin tests_failed++; $display("FAIL ra_flag got=%b exp=1", dut.dut1.read_addr_received); end
        @(negedge clk);
        tests_run++; if (dut.dut2.rd_addr !== 8'hF0) begin tests_failed++; $display("FAIL ra_addr got=%h exp=f0", dut.dut2.rd_addr); end
        end_txn();
    endtask

    task automatic test_read_data();
        logic [7:0] exp_byte;
        exp_byte = 8'hAE;
        send_frame(1'b1, 10'b11_0000_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.dut1.state !== READ_DATA) begin tests_failed++; $display("FAIL rd_state got=%0d exp=%0d", dut.dut1.state, READ_DATA); end
        tests_run++; if (dut.rx_valid !== 1'b1 || miso !== 1'b0) begin tests_failed++; $display("FAIL rd_rx got=%b/%b exp=1/0", dut.rx_valid, miso); end
        @(negedge clk);
        tests_run++; if (dut.tx_valid !== 1'b1 || dut.tx_data !== 8'hAE) begin tests_failed++; $display("FAIL rd_tx got=%b/%h exp=1/ae", dut.tx_valid, dut.tx_data); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++; if (miso !== exp_byte[7-i]) begin tests_failed++; $display("FAIL rd_miso_bit%0d got=%b exp=%b", 7 - i, miso, exp_byte[7-i]); end
        end
        @(negedge clk);
        tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL rd_miso_idle got=%b exp=0", miso); end
        tests_run++; if (dut.dut1.read_addr_received !== 1'b0) begin tests_failed++; $display("FAIL rd_flag_clr got=%b exp=0", dut.dut1.read_addr_received); end
        end_txn();
    endtask

    task automatic test_abort();
        int pulses_before;
        do_write(8'h20, 8'h33);
        pulses_before = rx_pulses;
        send_frame(1'b0, 10'b01_0101_0101, 5);
        end_txn();
        tests_run++; if (dut.dut1.state !== IDLE || dut.dut1.rx_cnt !== 4'd0) begin tests_failed++; $display("FAIL ab_idle got=%0d/%0d exp=%0d/0", dut.dut1.state, dut.dut1.rx_cnt, IDLE); end
        tests_run++; if (rx_pulses != pulses_before) begin tests_failed++; $display("FAIL ab_pulses got=%0d exp=%0d", rx_pulses, pulses_before); end
        tests_run++; if (dut.dut2.mem[8'h20] !== 8'h33) begin tests_failed++; $display("FAIL ab_mem got=%h exp=33", dut.dut2.mem[8'h20]); end
        send_frame(1'b0, 10'b01_0111_0111, 10);
        @(negedge clk);
        tests_run++; if (dut.rx_valid !== 1'b1 || dut.rx_data !== 10'h177) begin tests_failed++; $display("FAIL ab_next_rx got=%b/%h exp=1/177", dut.rx_valid, dut.rx_data); end
        @(negedge clk);
        tests_run++; if (dut.dut2.mem[8'h20] !== 8'h77) begin tests_failed++; $display("FAIL ab_next_mem got=%h exp=77", dut.dut2.mem[8'h20]); end
        end_txn();
    endtask

    // Read-data command with no prior read-address uses address 0 after reset
    task automatic test_read_default_addr();
        rst_n = 1'b0;
        #20;
        @(negedge clk); rst_n = 1'b1;
        do_write(8'h00, 8'hC3);
        send_frame(1'b1, 10'b11_0000_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.dut1.state !== READ_ADD) begin tests_failed++; $display("FAIL rdef_state got=%0d exp=%0d", dut.dut1.state, READ_ADD); end
        @(negedge clk);
        tests_run++; if (dut.tx_valid !== 1'b1 || dut.tx_data !== 8'hC3) begin tests_failed++; $display("FAIL rdef_tx got=%b/%h exp=1/c3", dut.tx_valid, dut.tx_data); end
        @(negedge clk);
        tests_run++; if (miso !== 1'b0) begin tests_failed++; $display("FAIL rdef_miso got=%b exp=0", miso); end
        end_txn();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rx_pulses    = 0;
        mosi         = 1'b0;
        ss_n         = 1'b1;
        rst_n        = 1'b1;
        test_reset();
        test_reset_keeps_mem();
        test_write_addr();
        test_write_data();
        test_read_addr();
        test_read_data();
        test_abort();
        test_read_default_addr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
